// File: rtl/dmem_responder.sv
// Handshaked data-memory slave: one word load/store at a time, programmable wait states,
// byte-enable writes and misaligned/out-of-range error reporting.
module dmem_responder #(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [31:0] AddrLimit = 32'(DEPTH * 4);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic          enter_resp;
  logic          mem_we;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic          cur_err;
  logic [AW-1:0] cur_idx;

  assign req_ready = (state_q == StIdle) & reset;
  assign accept    = req_ready & req_valid;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != StIdle);

  // With no wait states the response is formed on the acceptance edge, so the live request
  // fields must be used instead of the (not yet loaded) latched copies.
  always_comb begin
    if (state_q == StIdle) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
  end

  assign cur_err = (cur_addr[1:0] != 2'b00) | (cur_addr >= AddrLimit);
  assign cur_idx = cur_addr[AW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CW'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      // Counter runs WAIT_CYCLES down to 0 inclusive: WAIT_CYCLES+1 edges spent here.
      StWait: begin
        if (cnt_q == '0) begin
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_resp) begin
      state_d = StResp;
      err_d   = cur_err;
      rdata_d = (!cur_we && !cur_err) ? mem_q[cur_idx] : 32'h0;
    end
  end

  assign mem_we = enter_resp & cur_we & ~cur_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be[b]) begin
          mem_q[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

  logic        clk;
  logic        rst_n;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        req_valid0, req_ready0, req_we0;
  logic [31:0] req_addr0, req_wdata0;
  logic [3:0]  req_be0;
  logic        rsp_valid0, rsp_ready0, rsp_err0, busy0;
  logic [31:0] rsp_rdata0;

  int n_checks = 0;
  int n_pass   = 0;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut (
    .clk       (clk),
    .reset     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .reset     (rst_n),
    .req_valid (req_valid0),
    .req_ready (req_ready0),
    .req_we    (req_we0),
    .req_addr  (req_addr0),
    .req_wdata (req_wdata0),
    .req_be    (req_be0),
    .rsp_valid (rsp_valid0),
    .rsp_ready (rsp_ready0),
    .rsp_rdata (rsp_rdata0),
    .rsp_err   (rsp_err0),
    .busy      (busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at a negedge after the response handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wdata = 32'h5555_5555;
    req_be    = 4'hF;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = '0; req_wdata0 = '0; req_be0 = '0;
    rsp_ready0 = 1'b1;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata_err", {rsp_rdata[30:0], rsp_err}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // Basic store/load with latency check
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
    check("st10_lat", 32'(lat), 32'd3);
    check("st10_rdata", rd, 32'h0);
    check("st10_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("ld10_lat", 32'(lat), 32'd3);
    check("ld10_rdata", rd, 32'hDEAD_BEEF);

    // Byte merge
    txn(1'b1, 32'h20, 32'h1122_3344, 4'hF, rd, er, lat);
    txn(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
    txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
    check("merge_rdata", rd, 32'h11BB_33DD);

    // be=0000 store leaves word intact
    txn(1'b1, 32'h10, 32'h0BAD_0BAD, 4'h0, rd, er, lat);
    check("be0_err", 32'(er), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
    check("be0_rdata", rd, 32'hDEAD_BEEF);

    // Errors and boundaries
    txn(1'b1, 32'h00, 32'h0102_0304, 4'hF, rd, er, lat);
    txn(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
    check("mis_err", 32'(er), 32'd1);
    check("mis_rdata", rd, 32'h0);
    txn(1'b1, 32'h100, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
    check("oor_err", 32'(er), 32'd1);
    check("oor_lat", 32'(lat), 32'd3);
    txn(1'b0, 32'h00, 32'h0, 4'h0, rd, er, lat);
    check("ld00_unchanged", rd, 32'h0102_0304);
    check("ld00_err", 32'(er), 32'd0);
    txn(1'b1, 32'hFC, 32'h7654_3210, 4'hF, rd, er, lat);
    txn(1'b0, 32'hFC, 32'h0, 4'h0, rd, er, lat);
    check("top_rdata", rd, 32'h7654_3210);
    check("top_err", 32'(er), 32'd0);

    // Back-pressure; a request held during RESP must be ignored
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_we = 1'b1; req_addr = 32'h00; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("bp_done_valid", 32'(rsp_valid), 32'd0);
    check("bp_done_req_ready", 32'(req_ready), 32'd1);
    check("bp_done_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    txn(1'b0, 32'h00, 32'h0, 4'h0, rd, er, lat);
    check("bp_ignored_store", rd, 32'h0102_0304);

    // Reset abort during WAIT
    txn(1'b1, 32'h30, 32'h0, 4'hF, rd, er, lat);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFE_F00D;
    req_be = 4'hF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    check("abort_rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
    check("abort_ld30", rd, 32'h0);

    // Zero-wait instance, rsp_ready tied high
    req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'h04; req_wdata0 = 32'h5A5A_0001;
    req_be0 = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("z_st_valid", 32'(rsp_valid0), 32'd1);
    check("z_st_rdata", rsp_rdata0, 32'h0);
    req_we0 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("z_gap_valid", 32'(rsp_valid0), 32'd0);
    check("z_gap_req_ready", 32'(req_ready0), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("z_ld_valid", 32'(rsp_valid0), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) check("z_ld_rdata", rsp_rdata0, 32'h5A5A_0001);
    end
    req_valid0 = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
